// File: rtl/codix_risc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : codix_risc_mem_arbiter
// Purpose  : Arbitrates a single-port word memory between the RISC core and
//            a debug/loader port. Round-robin in normal operation; the debug
//            port can take exclusive ownership through a drain/lock handshake.
//            Illegal addresses never reach the memory and return an error
//            response (ERR_DATA on reads).
// Ports    : clk, rst_n                       clock / async active-low reset
//            core_* (req/we/addr/wdata in;    core access port
//                    gnt/rvalid/err/rdata out)
//            dbg_*  (same as core_*)          debug/loader access port
//            dbg_lock in / dbg_lock_ack out   exclusive ownership handshake
//            mem_en/we/addr/wdata out,        memory interface, read data one
//            mem_rdata in                     cycle after a read
// Revision : 1.0 - initial release
// ============================================================================
module codix_risc_mem_arbiter #(
  parameter int          ADDR_W    = 16,
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // core port
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic              core_err,
  output logic [31:0]       core_rdata,
  // debug/loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  input  logic              dbg_lock,
  output logic              dbg_lock_ack,
  // memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // One extra bit so MEM_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] c_mem_words = (ADDR_W+1)'(MEM_WORDS);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_dbg;   // 1: debug won the most recent grant
  logic              r_core_rv, r_core_err, r_core_ill;
  logic              r_dbg_rv, r_dbg_err, r_dbg_ill;

  logic              w_core_gnt, w_dbg_gnt, w_any_gnt;
  logic              w_core_legal, w_dbg_legal, w_sel_legal;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_core_rd_issue;

  assign w_core_legal = ({1'b0, core_addr} < c_mem_words);
  assign w_dbg_legal  = ({1'b0, dbg_addr}  < c_mem_words);

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (rst_n) begin
      if (r_state == ST_IDLE) begin
        if (core_req && dbg_req) begin
          // Tie: the port that did not win last time goes first.
          w_core_gnt = r_last_dbg;
          w_dbg_gnt  = ~r_last_dbg;
        end else begin
          w_core_gnt = core_req;
          w_dbg_gnt  = dbg_req;
        end
      end else begin
        w_dbg_gnt = dbg_req;
      end
    end
  end

  assign w_any_gnt   = w_core_gnt | w_dbg_gnt;
  assign w_sel_we    = w_dbg_gnt ? dbg_we      : core_we;
  assign w_sel_addr  = w_dbg_gnt ? dbg_addr    : core_addr;
  assign w_sel_wdata = w_dbg_gnt ? dbg_wdata   : core_wdata;
  assign w_sel_legal = w_dbg_gnt ? w_dbg_legal : w_core_legal;

  assign mem_en    = w_any_gnt & w_sel_legal;
  assign mem_we    = mem_en & w_sel_we;
  assign mem_addr  = mem_en ? w_sel_addr  : '0;
  assign mem_wdata = mem_en ? w_sel_wdata : '0;

  assign core_gnt = w_core_gnt;
  assign dbg_gnt  = w_dbg_gnt;

  // A core read granted this cycle would still be owed after the edge; the
  // response visible in the current cycle is already being delivered.
  assign w_core_rd_issue = w_core_gnt & ~core_we;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dbg_lock) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!dbg_lock)             w_state_next = ST_IDLE;
        else if (!w_core_rd_issue) w_state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!dbg_lock) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_dbg <= 1'b1;
      r_core_rv  <= 1'b0;
      r_core_err <= 1'b0;
      r_core_ill <= 1'b0;
      r_dbg_rv   <= 1'b0;
      r_dbg_err  <= 1'b0;
      r_dbg_ill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_any_gnt) r_last_dbg <= w_dbg_gnt;
      r_core_rv  <= w_core_gnt & ~core_we;
      r_core_err <= w_core_gnt & ~w_core_legal;
      r_core_ill <= ~w_core_legal;
      r_dbg_rv   <= w_dbg_gnt & ~dbg_we;
      r_dbg_err  <= w_dbg_gnt & ~w_dbg_legal;
      r_dbg_ill  <= ~w_dbg_legal;
    end
  end

  assign core_rvalid  = r_core_rv;
  assign core_err     = r_core_err;
  assign core_rdata   = r_core_rv ? (r_core_ill ? ERR_DATA : mem_rdata) : '0;
  assign dbg_rvalid   = r_dbg_rv;
  assign dbg_err      = r_dbg_err;
  assign dbg_rdata    = r_dbg_rv ? (r_dbg_ill ? ERR_DATA : mem_rdata) : '0;
  assign dbg_lock_ack = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_codix_risc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_codix_risc_mem_arbiter
// Purpose  : Directed self-checking bench for codix_risc_mem_arbiter with a
//            256-word memory model and a response scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_codix_risc_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int MEM_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [ADDR_W-1:0] core_addr, dbg_addr;
  logic [31:0]       core_wdata, dbg_wdata;
  logic              core_gnt, core_rvalid, core_err;
  logic              dbg_gnt, dbg_rvalid, dbg_err, dbg_lock_ack;
  logic [31:0]       core_rdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        crv;
    logic        cerr;
    logic [31:0] crd;
    logic        drv;
    logic        derr;
    logic [31:0] drd;
  } resp_t;

  resp_t q[$];

  always #5 clk = ~clk;

  codix_risc_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_err    (core_err),
    .core_rdata  (core_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_err     (dbg_err),
    .dbg_rdata   (dbg_rdata),
    .dbg_lock    (dbg_lock),
    .dbg_lock_ack(dbg_lock_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Memory model: preloaded with 0xA500_0000|index, word 0x10 = 0x1234_5678.
  logic [31:0] tbmem [MEM_WORDS];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MEM_WORDS; i++)
        tbmem[i] <= (i == 16) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic resp_t rsp(input logic crv, cerr, input logic [31:0] crd,
                                input logic drv, derr, input logic [31:0] drd);
    resp_t r;
    r.crv = crv; r.cerr = cerr; r.crd = crd;
    r.drv = drv; r.derr = derr; r.drd = drd;
    return r;
  endfunction

  function automatic resp_t none();
    return rsp(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".core_gnt"},    core_gnt,     0);
    chk({tag, ".dbg_gnt"},     dbg_gnt,      0);
    chk({tag, ".core_rvalid"}, core_rvalid,  0);
    chk({tag, ".dbg_rvalid"},  dbg_rvalid,   0);
    chk({tag, ".core_err"},    core_err,     0);
    chk({tag, ".dbg_err"},     dbg_err,      0);
    chk({tag, ".lock_ack"},    dbg_lock_ack, 0);
    chk({tag, ".mem_en"},      mem_en,       0);
    chk({tag, ".mem_we"},      mem_we,       0);
    chk({tag, ".core_rdata"},  core_rdata,   0);
    chk({tag, ".dbg_rdata"},   dbg_rdata,    0);
    chk({tag, ".mem_addr"},    32'(mem_addr), 0);
    chk({tag, ".mem_wdata"},   mem_wdata,    0);
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational grant/memory outputs, queues the response expected after
  // the next edge, then crosses the edge and scores that response.
  task automatic cyc(input string tag, input logic cg, dg, me, mwe,
                     input logic [15:0] ma, input logic ack, input resp_t nxt);
    resp_t r;
    #2;
    chk({tag, ".core_gnt"}, core_gnt,     32'(cg));
    chk({tag, ".dbg_gnt"},  dbg_gnt,      32'(dg));
    chk({tag, ".mem_en"},   mem_en,       32'(me));
    chk({tag, ".mem_we"},   mem_we,       32'(mwe));
    chk({tag, ".lock_ack"}, dbg_lock_ack, 32'(ack));
    if (me) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ma));
    q.push_back(nxt);
    @(posedge clk);
    #1;
    r = q.pop_front();
    chk({tag, ".core_rvalid"}, core_rvalid, 32'(r.crv));
    chk({tag, ".core_err"},    core_err,    32'(r.cerr));
    chk({tag, ".core_rdata"},  core_rdata,  r.crd);
    chk({tag, ".dbg_rvalid"},  dbg_rvalid,  32'(r.drv));
    chk({tag, ".dbg_err"},     dbg_err,     32'(r.derr));
    chk({tag, ".dbg_rdata"},   dbg_rdata,   r.drd);
  endtask

  initial begin
    // Reset with every request active: outputs must stay at 0.
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0003; core_wdata = 32'h1;
    dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 16'h0004; dbg_wdata  = 32'h2;
    dbg_lock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    core_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin on held simultaneous reads: core, dbg, core, dbg.
    core_req = 1'b1; core_addr = 16'h0001;
    dbg_req  = 1'b1; dbg_addr  = 16'h0002;
    cyc("rr0", 1, 0, 1, 0, 16'h0001, 0, rsp(1, 0, 32'hA500_0001, 0, 0, 0));
    cyc("rr1", 0, 1, 1, 0, 16'h0002, 0, rsp(0, 0, 0, 1, 0, 32'hA500_0002));
    cyc("rr2", 1, 0, 1, 0, 16'h0001, 0, rsp(1, 0, 32'hA500_0001, 0, 0, 0));
    cyc("rr3", 0, 1, 1, 0, 16'h0002, 0, rsp(0, 0, 0, 1, 0, 32'hA500_0002));

    // Lone core read.
    dbg_req = 1'b0; core_addr = 16'h0010;
    cyc("rd_core", 1, 0, 1, 0, 16'h0010, 0, rsp(1, 0, 32'h1234_5678, 0, 0, 0));

    // Debug write then read-back; no rvalid for the write.
    core_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 32'hCAFE_F00D;
    #1;
    chk("wr_dbg.mem_wdata", mem_wdata, 32'hCAFE_F00D);
    cyc("wr_dbg", 0, 1, 1, 1, 16'h0020, 0, none());
    dbg_we = 1'b0;
    cyc("rd_dbg", 0, 1, 1, 0, 16'h0020, 0, rsp(0, 0, 0, 1, 0, 32'hCAFE_F00D));

    // Illegal core read at MEM_WORDS; illegal debug write.
    dbg_req = 1'b0;
    core_req = 1'b1; core_addr = 16'h0100;
    cyc("ill_rd", 1, 0, 0, 0, 16'h0, 0, rsp(1, 1, 32'hDEAD_BEEF, 0, 0, 0));
    core_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h01FF;
    cyc("ill_wr", 0, 1, 0, 0, 16'h0, 0, rsp(0, 0, 0, 0, 1, 0));

    // Tie after a debug win goes to core.
    dbg_we = 1'b0; dbg_addr = 16'h0004;
    core_req = 1'b1; core_addr = 16'h0003;
    cyc("tie", 1, 0, 1, 0, 16'h0003, 0, rsp(1, 0, 32'hA500_0003, 0, 0, 0));

    // Lock raised in the grant cycle of a core read.
    dbg_req = 1'b0;
    core_addr = 16'h0010; dbg_lock = 1'b1;
    cyc("lk_grant", 1, 0, 1, 0, 16'h0010, 0, rsp(1, 0, 32'h1234_5678, 0, 0, 0));
    core_addr = 16'h0011;
    cyc("lk_drain", 0, 0, 0, 0, 16'h0, 0, none());
    dbg_req = 1'b1; dbg_addr = 16'h0020;
    cyc("lk_dbg", 0, 1, 1, 0, 16'h0020, 1, rsp(0, 0, 0, 1, 0, 32'hCAFE_F00D));
    dbg_req = 1'b0;
    cyc("lk_hold", 0, 0, 0, 0, 16'h0, 1, none());
    dbg_lock = 1'b0;
    cyc("lk_rel", 0, 0, 0, 0, 16'h0, 1, none());
    cyc("lk_idle", 1, 0, 1, 0, 16'h0011, 0, rsp(1, 0, 32'hA500_0011, 0, 0, 0));

    // Reset in the cycle after a core read grant (core won last).
    core_addr = 16'h0010;
    #2;
    chk("rst_mid.core_gnt", core_gnt, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dbg_req = 1'b1;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    core_req = 1'b0; dbg_req = 1'b0;
    rst_n = 1'b1;
    cyc("post_rst", 0, 0, 0, 0, 16'h0, 0, none());

    // First tie after reset goes to core, then debug.
    core_req = 1'b1; core_addr = 16'h0005;
    dbg_req  = 1'b1; dbg_addr  = 16'h0006;
    cyc("tie_rst0", 1, 0, 1, 0, 16'h0005, 0, rsp(1, 0, 32'hA500_0005, 0, 0, 0));
    cyc("tie_rst1", 0, 1, 1, 0, 16'h0006, 0, rsp(0, 0, 0, 1, 0, 32'hA500_0006));
    core_req = 1'b0; dbg_req = 1'b0;
    cyc("tail", 0, 0, 0, 0, 16'h0, 0, none());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/codix_risc_mem_arbiter.md
CODIX_RISC_MEM_ARBITER -- requirements
Module: codix_risc_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of all address ports.
REQ-002 Parameter MEM_WORDS, default 65536, number of implemented memory words; legal addresses are 0..MEM_WORDS-1.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned for an illegal address.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, asynchronous and active-low.
REQ-006 core_req / core_we  in  1 / 1  core access request / write enable.
REQ-007 core_addr / core_wdata  in  ADDR_W / 32  core word address / write data.
REQ-008 core_gnt / core_rvalid / core_err  out  1 / 1 / 1  core grant / read-data valid / illegal-address flag.
REQ-009 core_rdata  out  32  core read data.
REQ-010 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata: debug/loader port, same widths and meanings as the core port.
REQ-011 dbg_lock  in  1  debug requests exclusive memory ownership.
REQ-012 dbg_lock_ack  out  1  exclusive ownership granted to debug.
REQ-013 mem_en / mem_we  out  1 / 1  memory enable / write.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / 32  memory address / write data.
REQ-015 mem_rdata  in  32  memory read data, valid exactly 1 cycle after a read with mem_en=1.

Function
REQ-016 Grants are combinational from requests and registered state; at most one of core_gnt/dbg_gnt is 1 per cycle.
REQ-017 A granted request with a legal address drives mem_en=1 with the winner's we/addr/wdata in the same cycle; otherwise mem_en=0 and mem_we=0.
REQ-018 A granted request with an illegal address still asserts the grant, drives mem_en=0, and pulses the owner's err for 1 cycle in the following cycle.
REQ-019 A granted read pulses the owner's rvalid for exactly 1 cycle, 1 cycle after grant; rdata = mem_rdata if legal, else ERR_DATA.
REQ-020 Writes produce no rvalid; a granted illegal write only raises err.
REQ-021 Unowned rdata outputs are 0 whenever their rvalid is 0.
REQ-022 Arbitration in state IDLE: round-robin on a 1-bit last-winner register; on simultaneous requests the port that did not win last gets the grant; a lone requester is always granted.
REQ-023 Last-winner updates only on a cycle in which a grant is issued.
REQ-024 Lock FSM states: IDLE, DRAIN, LOCKED.
REQ-025 IDLE -> DRAIN when dbg_lock=1; in DRAIN and LOCKED core_gnt=0 regardless of core_req.
REQ-026 DRAIN -> LOCKED on the first cycle in which no core read response is outstanding; with nothing outstanding this takes exactly 1 cycle.
REQ-027 dbg_lock_ack=1 only in LOCKED.
REQ-028 Debug is granted in DRAIN and LOCKED whenever dbg_req=1.
REQ-029 dbg_lock=0 in DRAIN or LOCKED -> IDLE the next cycle; a response already in flight is still delivered to its owner.
REQ-030 Requests are not queued; an ungranted requester holds req/we/addr/wdata stable until granted.

Reset
REQ-031 While RST=0: FSM=IDLE, last-winner=debug (core wins first tie), no outstanding response, all gnt/rvalid/err/dbg_lock_ack/mem_en/mem_we = 0, all rdata/mem_addr/mem_wdata = 0.
REQ-032 Reset asserted mid-read discards the pending response; no rvalid appears after release.
REQ-033 First grant is possible in the first rising edge cycle after RST deasserts.

Verification
REQ-034 Core read addr 0x0010, mem returns 0x1234_5678 -> core_gnt same cycle, mem_en=1/mem_we=0/mem_addr=0x0010, core_rvalid=1 with core_rdata=0x1234_5678 next cycle.
REQ-035 core_req and dbg_req held 1 for 4 cycles after reset -> grants core, dbg, core, dbg.
REQ-036 Debug write addr 0x0020 data 0xCAFE_F00D, then debug read same addr -> mem_we=1 then dbg_rdata=0xCAFE_F00D; no dbg_rvalid for the write.
REQ-037 Core read addr MEM_WORDS (MEM_WORDS=256, addr 0x0100) -> core_gnt=1, mem_en=0, next cycle core_rvalid=1, core_err=1, core_rdata=0xDEAD_BEEF.
REQ-038 dbg_lock raised in the grant cycle of a core read -> DRAIN, core_rvalid delivered next cycle, dbg_lock_ack=1 the following cycle, core_req=1 ungranted until dbg_lock=0, then IDLE.
REQ-039 RST=0 asserted in the cycle after a core read grant -> no core_rvalid after release, all outputs 0, first tie goes to core.
